// File: rtl/alu_md_pkg.sv
// Shared definitions for the ALU with iterative multiply/divide:
// operation encodings, FSM states and the iterative-op selector.
package alu_md_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MUL  = 4'b0011;
    localparam logic [3:0] ALU_DIVU = 4'b0100;
    localparam logic [3:0] ALU_REMU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_EQ   = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [1:0] {IT_MUL, IT_DIVU, IT_REMU} iter_op_t;

    function automatic logic isIterOp(input logic [3:0] sel);
        return (sel == ALU_MUL) || (sel == ALU_DIVU) || (sel == ALU_REMU);
    endfunction

    function automatic iter_op_t toIterOp(input logic [3:0] sel);
        case (sel)
            ALU_DIVU: return IT_DIVU;
            ALU_REMU: return IT_REMU;
            default:  return IT_MUL;
        endcase
    endfunction

endpackage

// File: rtl/alu_md_if.sv
// Request/response bundle between a requester (master) and the ALU (slave).
interface alu_md_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [3:0]       ALU_Sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             Zero;
    logic             Carry_Out;
    logic             Overflow;

    modport slave (
        input  in_valid, A_in, B_in, ALU_Sel, out_ready,
        output in_ready, out_valid, ALU_Out, Zero, Carry_Out, Overflow
    );

    modport master (
        output in_valid, A_in, B_in, ALU_Sel, out_ready,
        input  in_ready, out_valid, ALU_Out, Zero, Carry_Out, Overflow
    );

endinterface

// File: rtl/alu_md_iter.sv
// Iterative datapath: shift-add multiply (low half) and restoring unsigned
// divide, one step per cycle for exactly WIDTH cycles after i_start.
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  iter_op_t         i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    // x: accumulator / partial remainder, y: multiplicand / divisor,
    // z: multiplier / dividend shifting into quotient
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    iter_op_t         r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;

    logic [WIDTH-1:0] w_mulAcc;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;

    assign w_mulAcc  = r_x + (r_z[0] ? r_y : '0);
    assign w_shift   = {r_x, r_z[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_y};
    assign w_fits    = ~w_trial[WIDTH];
    assign w_remNext = w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quoNext = {r_z[WIDTH-2:0], w_fits};

    // Result reflects the step being taken this cycle, so the parent can
    // register it on the same edge that ends the last step.
    assign o_done   = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_result = (r_op == IT_MUL)  ? w_mulAcc :
                      (r_op == IT_DIVU) ? w_quoNext : w_remNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op   <= IT_MUL;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_op   <= i_op;
            r_x    <= '0;
            r_y    <= (i_op == IT_MUL) ? i_a : i_b;
            r_z    <= (i_op == IT_MUL) ? i_b : i_a;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
            if (r_op == IT_MUL) begin
                r_x <= w_mulAcc;
                r_y <= r_y << 1;
                r_z <= r_z >> 1;
            end else begin
                r_x <= w_remNext;
                r_z <= w_quoNext;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative
// MUL/DIVU/REMU, with result and flags held until the consumer accepts.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_md_if.slave     bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_aluOut;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;
    logic             r_inReady;
    logic             r_outValid;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [3:0]       w_sel;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;
    logic             w_accept;
    logic             w_iterStart;
    logic             w_iterDone;
    logic [WIDTH-1:0] w_iterRes;

    assign w_a         = bus.A_in;
    assign w_b         = bus.B_in;
    assign w_sel       = bus.ALU_Sel;
    assign w_shamt     = bus.B_in[SHW-1:0];
    assign w_accept    = (r_state == IDLE) && bus.in_valid;
    assign w_iterStart = w_accept && isIterOp(w_sel);

    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = w_a - w_b;

    // Evaluated on the request being accepted, so the result register is
    // loaded on the same edge that latches the request.
    always_comb begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_sel)
            ALU_AND:  w_res = w_a & w_b;
            ALU_OR:   w_res = w_a | w_b;
            ALU_NOR:  w_res = ~(w_a | w_b);
            ALU_SUB: begin
                w_res   = w_diff;
                w_carry = (w_a >= w_b);
                w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            ALU_EQ:   w_res = {{(WIDTH-1){1'b0}}, (w_a == w_b)};
            ALU_SLL:  w_res = w_a << w_shamt;
            ALU_SRL:  w_res = w_a >> w_shamt;
            ALU_SRA:  w_res = $signed(w_a) >>> w_shamt;
            ALU_MUL, ALU_DIVU, ALU_REMU: w_res = '0;
            default: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iterStart),
        .i_op     (toIterOp(w_sel)),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_done   (w_iterDone),
        .o_result (w_iterRes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_aluOut   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_inReady <= 1'b0;
                        if (isIterOp(w_sel)) begin
                            r_state <= BUSY;
                        end else begin
                            r_state    <= DONE;
                            r_outValid <= 1'b1;
                            r_aluOut   <= w_res;
                            r_zero     <= (w_res == '0);
                            r_carry    <= w_carry;
                            r_ovf      <= w_ovf;
                        end
                    end
                end
                BUSY: begin
                    if (w_iterDone) begin
                        r_state    <= DONE;
                        r_outValid <= 1'b1;
                        r_aluOut   <= w_iterRes;
                        r_zero     <= (w_iterRes == '0);
                        r_carry    <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.ALU_Out   = r_aluOut;
    assign bus.Zero      = r_zero;
    assign bus.Carry_Out = r_carry;
    assign bus.Overflow  = r_ovf;

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, even).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from B_in[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand/op request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 A_in, B_in  input  WIDTH each  operands.
REQ-008 ALU_Sel  input  4  operation select (encodings per REQ-013).
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALU_Out  output  WIDTH  registered result.
REQ-012 Zero, Carry_Out, Overflow  output  1 each  registered flags belonging to ALU_Out.

Function
REQ-013 Ops: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 1100 NOR, 1111 EQ (1/0), 1000 SLTU, 1001 SLL, 1010 SRL, 1011 SRA, 0011 MUL (low WIDTH bits), 0100 DIVU, 0101 REMU; any other code SHALL perform ADD.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: in_valid=1 SHALL latch A_in, B_in, ALU_Sel; single-cycle ops -> DONE next edge; MUL/DIVU/REMU -> BUSY.
REQ-016 BUSY SHALL last exactly WIDTH cycles (counter 0..WIDTH-1), one shift-add or restoring-divide step per cycle, then -> DONE.
REQ-017 Latency accept-edge to out_valid: 1 cycle single-cycle ops; WIDTH+1 cycles MUL/DIVU/REMU.
REQ-018 DONE: ALU_Out and flags SHALL hold stable until out_valid&&out_ready, then -> IDLE; no new request accepted in same cycle.
REQ-019 Zero SHALL equal (ALU_Out==0) for every op.
REQ-020 ADD: Carry_Out = unsigned carry from bit WIDTH-1; Overflow = operands same sign and result sign differs.
REQ-021 SUB: Carry_Out = 1 iff A_in>=B_in unsigned; Overflow = operand signs differ and result sign differs from A_in.
REQ-022 All other ops SHALL drive Carry_Out=0, Overflow=0.
REQ-023 Shifts SHALL use B_in[SHW-1:0] only; SRA sign-fills.
REQ-024 DIVU by zero: quotient all ones; REMU by zero: remainder = A_in; no exception signalled.
REQ-025 Input changes while not IDLE SHALL have no effect on the operation in flight.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, counter 0, ALU_Out 0, Zero 0, Carry_Out 0, Overflow 0, out_valid 0; in_ready 1 after release.
REQ-027 Reset asserted in BUSY or DONE SHALL discard the operation; no out_valid after release.

Structure
REQ-028 Shared package alu_md_pkg SHALL hold ALU_Sel encoding constants and the FSM state typedef.
REQ-029 Iterative multiply/divide datapath SHALL be sub-module alu_md_iter (start, op, operands in; done, result out), WIDTH-parametrised.
REQ-030 Single-cycle ops SHALL be combinational from latched operands within alu_md.

Verification (WIDTH=32)
REQ-031 ADD 0x7FFFFFFF+0x00000001 -> ALU_Out 0x80000000, Overflow 1, Carry_Out 0, Zero 0, out_valid 1 cycle after accept.
REQ-032 SUB 5-5 -> ALU_Out 0, Zero 1, Carry_Out 1; SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
REQ-033 MUL 0x00010000*0x00010000 -> 0x00000000, Zero 1, out_valid exactly 33 cycles after accept; DIVU 100/7 -> 14, REMU -> 2.
REQ-034 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
REQ-035 out_ready held 0 for 10 cycles in DONE -> ALU_Out/flags stable, in_ready 0, in_valid pulses ignored; release -> IDLE next edge.
REQ-036 rst_n low at BUSY cycle 10 of MUL -> all outputs 0 immediately, no out_valid after release; next ADD 2+3 -> 5.
